// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the serial-to-word deserializer.
// Build option: DESER_PARITY_EN appends an even-parity bit to every frame.
package deser_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_HOLD,
        S_STALL
    } state_t;

`ifdef DESER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int DEF_WIDTH = 32;
    localparam int FRAME_LEN = DEF_WIDTH + PARITY_BITS;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    // Frame length and counter width for an arbitrary word width.
    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

    function automatic int cnt_w(input int width);
        return $clog2(frame_len(width) + 1);
    endfunction

endpackage

// File: rtl/deser_out_slot.sv
// Single-entry output register with valid/ready semantics.
// A load in the same cycle as a drain keeps the slot full with the new data.
module deser_out_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          drain,
    output logic [DW-1:0] data,
    output logic          valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain && valid) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/word_deserializer.sv
// Collects an MSB-first serial stream into WIDTH-bit words behind a valid/ready slot.
// Build option: DESER_PARITY_EN adds a trailing even-parity bit and the parity_err port.
module word_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_bit,
    input  logic             ser_valid,
    input  logic             ser_sof,
    output logic             ser_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             frame_err
`ifdef DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int FLEN = frame_len(WIDTH);
    localparam int CW   = cnt_w(WIDTH);
    localparam int DW   = WIDTH + PARITY_BITS;

    state_t           state;
    logic [WIDTH-1:0] shift;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    eff_cnt;
    logic             accept;
    logic             restart;
    logic             complete;
    logic             handshake;
    logic             slot_load;
    logic             is_parity_bit;
    logic [DW-1:0]    slot_in;
    logic [DW-1:0]    slot_q;

    assign accept    = ser_valid && ser_ready;
    assign restart   = accept && ser_sof && (cnt != '0);
    // An early start-of-frame makes the current bit position 0 again.
    assign eff_cnt   = (ser_sof && cnt != '0) ? '0 : cnt;
    assign complete  = accept && (eff_cnt == CW'(FLEN - 1));
    assign handshake = word_valid && word_ready;

`ifdef DESER_PARITY_EN
    logic pend_perr;
    logic done_perr;

    // The parity bit is not shifted in, so shift already holds the full word.
    assign is_parity_bit = (eff_cnt == CW'(WIDTH));
    assign done_perr     = (^shift) ^ ser_bit;
    assign slot_in       = (state == S_STALL) ? {pend_perr, shift} : {done_perr, shift};
    assign word_out      = slot_q[WIDTH-1:0];
    assign parity_err    = slot_q[WIDTH];

    always_ff @(posedge clk) begin
        if (rst)
            pend_perr <= 1'b0;
        else if (complete)
            pend_perr <= done_perr;
    end
`else
    assign is_parity_bit = 1'b0;
    assign slot_in       = (state == S_STALL) ? shift : {shift[WIDTH-2:0], ser_bit};
    assign word_out      = slot_q;
`endif

    assign slot_load = (state == S_STALL) ? handshake
                                          : (complete && (state == S_FILL || handshake));

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift     <= '0;
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= restart;
            if (accept) begin
                if (!is_parity_bit)
                    shift <= {shift[WIDTH-2:0], ser_bit};
                cnt <= complete ? '0 : eff_cnt + CW'(1);
            end
        end
    end

    // ser_ready is a registered copy of (state != S_STALL), never a function of word_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FILL;
            ser_ready <= 1'b1;
        end else begin
            case (state)
                S_FILL: begin
                    if (complete)
                        state <= S_HOLD;
                end
                S_HOLD: begin
                    if (complete && !handshake) begin
                        state     <= S_STALL;
                        ser_ready <= 1'b0;
                    end else if (!complete && handshake) begin
                        state <= S_FILL;
                    end
                end
                S_STALL: begin
                    if (handshake) begin
                        state     <= S_HOLD;
                        ser_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_FILL;
                    ser_ready <= 1'b1;
                end
            endcase
        end
    end

    deser_out_slot #(.DW(DW)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_load),
        .load_data (slot_in),
        .drain     (word_ready),
        .data      (slot_q),
        .valid     (word_valid)
    );

endmodule

// File: tb/tb_word_deserializer.sv
// Directed bench for word_deserializer: word table plus stall, early-SOF and reset sequences.
// Parity vectors are exercised when DESER_PARITY_EN is defined.
module tb_word_deserializer;

    localparam int WIDTH = 32;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             ser_bit    = 1'b0;
    logic             ser_valid  = 1'b0;
    logic             ser_sof    = 1'b0;
    logic             word_ready = 1'b0;
    logic             ser_ready;
    logic             word_valid;
    logic             frame_err;
    logic [WIDTH-1:0] word_out;
`ifdef DESER_PARITY_EN
    logic             parity_err;
`endif

    int               checks   = 0;
    int               failures = 0;
    int               fe_count = 0;
    logic [WIDTH-1:0] got[$];

    always #5 clk = ~clk;

    word_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .ser_sof    (ser_sof),
        .ser_ready  (ser_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err)
`ifdef DESER_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    // Record delivered words and frame_err cycles mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        if (!rst && word_valid && word_ready)
            got.push_back(word_out);
        if (frame_err)
            fe_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic sof);
        check_bit("ser_ready_on_send", ser_ready, 1'b1);
        ser_bit   = b;
        ser_sof   = sof;
        ser_valid = 1'b1;
        step();
        ser_valid = 1'b0;
        ser_sof   = 1'b0;
    endtask

    // mode 0: back-to-back bits; 1: idle cycle between bits; 2: idle cycle with ser_sof high mid-word
    task automatic send_word(input logic [WIDTH-1:0] data, input int mode);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(data[i], i == WIDTH - 1);
            if (mode == 1 && i != 0)
                step();
            if (mode == 2 && i == WIDTH - 6) begin
                ser_sof = 1'b1;
                step();
                ser_sof = 1'b0;
            end
        end
`ifdef DESER_PARITY_EN
        send_bit(^data, 1'b0);
`endif
    endtask

    typedef struct {
        logic [WIDTH-1:0] data;
        int               mode;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [9:0]       partial;
        logic [WIDTH-1:0] d;

        vecs[0] = '{32'h8000_0001, 0, 32'h8000_0001};
        vecs[1] = '{32'h1234_5678, 1, 32'h1234_5678};
        vecs[2] = '{32'hFFFF_FFFF, 0, 32'hFFFF_FFFF};
        vecs[3] = '{32'h0000_0000, 2, 32'h0000_0000};
        vecs[4] = '{32'hAAAA_5555, 0, 32'hAAAA_5555};

        // Reset values
        rst = 1'b1;
        repeat (3) step();
        check_bit("rst_ser_ready", ser_ready, 1'b1);
        check_bit("rst_word_valid", word_valid, 1'b0);
        check("rst_word_out", word_out, 32'h0);
        check_bit("rst_frame_err", frame_err, 1'b0);
        rst = 1'b0;
        step();

        // Word table, consumer always ready
        word_ready = 1'b1;
        got.delete();
        fe_count = 0;
        foreach (vecs[i]) begin
            send_word(vecs[i].data, vecs[i].mode);
            check_bit("tbl_valid", word_valid, 1'b1);
            check("tbl_word", word_out, vecs[i].exp);
            step();
            check_bit("tbl_drained", word_valid, 1'b0);
        end
        check("tbl_no_frame_err", fe_count, 0);
        check("tbl_count", got.size(), 5);

        // Back-to-back words at full rate: send_bit flags any ser_ready drop
        got.delete();
        send_word(32'hDEAD_BEEF, 0);
        send_word(32'h0F0F_F0F0, 0);
        check("b2b_word", word_out, 32'h0F0F_F0F0);
        step();
        check("b2b_count", got.size(), 2);
        check("b2b_first", got[0], 32'hDEAD_BEEF);

        // Backpressure: second word stalls until the slot is consumed
        got.delete();
        word_ready = 1'b0;
        send_word(32'hA5A5_A5A5, 0);
        check_bit("bp_first_valid", word_valid, 1'b1);
        send_word(32'h0000_0001, 0);
        check_bit("bp_stall_ready", ser_ready, 1'b0);
        check("bp_slot_holds_first", word_out, 32'hA5A5_A5A5);
        repeat (8) step();
        check_bit("bp_still_stalled", ser_ready, 1'b0);
        check_bit("bp_still_valid", word_valid, 1'b1);
        word_ready = 1'b1;
        step();
        check_bit("bp_reload_valid", word_valid, 1'b1);
        check("bp_reload_word", word_out, 32'h0000_0001);
        check_bit("bp_ready_back", ser_ready, 1'b1);
        step();
        check_bit("bp_drained", word_valid, 1'b0);
        check("bp_count", got.size(), 2);
        if (got.size() == 2) begin
            check("bp_order0", got[0], 32'hA5A5_A5A5);
            check("bp_order1", got[1], 32'h0000_0001);
        end

        // Early start-of-frame discards a 10-bit partial
        got.delete();
        fe_count = 0;
        partial  = 10'b10_1100_1110;
        for (int i = 9; i >= 0; i--)
            send_bit(partial[i], i == 9);
        send_bit(1'b1, 1'b1);
        check_bit("sof_frame_err", frame_err, 1'b1);
        d = 32'hFFFF_0000;
        for (int i = WIDTH - 2; i >= 0; i--)
            send_bit(d[i], 1'b0);
`ifdef DESER_PARITY_EN
        send_bit(^d, 1'b0);
`endif
        check("sof_word", word_out, 32'hFFFF_0000);
        step();
        check("sof_pulse_cycles", fe_count, 1);
        check("sof_count", got.size(), 1);

        // Reset while stalled, then reset mid-word
        word_ready = 1'b0;
        send_word(32'h1111_2222, 0);
        send_word(32'h3333_4444, 0);
        check_bit("rs_stalled", ser_ready, 1'b0);
        ser_valid = 1'b1;
        ser_sof   = 1'b1;
        step();
        ser_valid = 1'b0;
        ser_sof   = 1'b0;
        check_bit("rs_sof_ignored", frame_err, 1'b0);
        rst = 1'b1;
        step();
        check_bit("rs_valid", word_valid, 1'b0);
        check_bit("rs_ready", ser_ready, 1'b1);
        check("rs_word_out", word_out, 32'h0);
        rst = 1'b0;
        word_ready = 1'b1;
        for (int i = 0; i < 7; i++)
            send_bit(1'b1, i == 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        got.delete();
        send_word(32'hC3C3_0F0F, 0);
        check("rs_clean_word", word_out, 32'hC3C3_0F0F);
        step();
        check("rs_count", got.size(), 1);

`ifdef DESER_PARITY_EN
        // Parity: data 0x3 has even parity 0, so a parity bit of 1 is a mismatch
        d = 32'h0000_0003;
        for (int i = WIDTH - 1; i >= 0; i--)
            send_bit(d[i], i == WIDTH - 1);
        send_bit(1'b1, 1'b0);
        check("par_bad_word", word_out, 32'h0000_0003);
        check_bit("par_bad_flag", parity_err, 1'b1);
        step();
        for (int i = WIDTH - 1; i >= 0; i--)
            send_bit(d[i], i == WIDTH - 1);
        send_bit(1'b0, 1'b0);
        check("par_good_word", word_out, 32'h0000_0003);
        check_bit("par_good_flag", parity_err, 1'b0);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
